// File: rtl/demux_1_2_buf_if.sv
// Bundle of handshake and data signals around the 1:2 buffered demux.
// Ports: in_* (word, select, valid/ready), out0_*/out1_* (head word,
//        valid/ready, occupancy) for each destination channel.
// slave = the demux itself; master = the producer/consumer environment.
interface demux_1_2_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [CW-1:0]    out0_count;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    out1_count;

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready,
    output out0_data, out0_valid, out0_count,
    output out1_data, out1_valid, out1_count
  );

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready,
    input  out0_data, out0_valid, out0_count,
    input  out1_data, out1_valid, out1_count
  );
endinterface

// File: rtl/demux_1_2_buf.sv
// Purpose: steer one result stream to one of two channels (in_sel), each with its own FIFO.
// Latency: accepted word visible on its outN_data/outN_valid one cycle after the accept edge.
// Backpressure: in_ready drops only when the selected channel is full; the other channel keeps flowing.
// Ports: clk, rst_n (async active-low), bus (slave modport of demux_1_2_buf_if).
module demux_1_2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1_2_buf_if.slave       bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NCH = 2;

  logic [WIDTH-1:0] mem    [NCH][DEPTH];
  logic [PW-1:0]    wr_ptr [NCH];
  logic [PW-1:0]    rd_ptr [NCH];
  logic [CW-1:0]    count  [NCH];

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   out_ready;
  logic             in_ready;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Fullness comes only from the registered count, so a pop in the same
  // cycle never frees a slot for an incoming word; the slot opens next cycle.
  assign in_ready     = !full[bus.in_sel];
  assign bus.in_ready = in_ready;

  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      full[ch] = (count[ch] == CW'(DEPTH));
      push[ch] = bus.in_valid && in_ready && (bus.in_sel == 1'(ch));
      // Popping an empty channel is ignored regardless of outN_ready.
      pop[ch]  = (count[ch] != '0) && out_ready[ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[ch][i] <= '0;
        end
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
        count[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (push[ch]) begin
          mem[ch][wr_ptr[ch]] <= bus.in_data;
          wr_ptr[ch]          <= wr_ptr[ch] + PW'(1);
        end
        if (pop[ch]) begin
          rd_ptr[ch] <= rd_ptr[ch] + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push[ch], pop[ch]})
          2'b10:   count[ch] <= count[ch] + CW'(1);
          2'b01:   count[ch] <= count[ch] - CW'(1);
          default: count[ch] <= count[ch];
        endcase
      end
    end
  end

  // Outputs are read straight from registered state: no in-to-out bypass.
  assign bus.out0_data  = mem[0][rd_ptr[0]];
  assign bus.out0_valid = (count[0] != '0);
  assign bus.out0_count = count[0];

  assign bus.out1_data  = mem[1][rd_ptr[1]];
  assign bus.out1_valid = (count[1] != '0);
  assign bus.out1_count = count[1];

endmodule

// File: doc/demux_1_2_buf.md
Name: demux_1_2_buf

Overview:
- Inverse of the datapath 2:1 select: one 32-bit result stream in, steered by a per-word select bit to one of two destinations.
- Each destination has its own small FIFO with a valid/ready handshake, so a stalled destination does not block traffic bound for the other.
- Sits between the execute/load-store result path and its two consumers: register-file writeback (channel 0) and the secondary sink (channel 1).

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block can accept the word for the destination selected by in_sel
- out0_data  output  WIDTH  channel 0 head word
- out0_valid  output  1  channel 0 FIFO non-empty
- out0_ready  input  1  channel 0 consumer accepts
- out1_data  output  WIDTH  channel 1 head word
- out1_valid  output  1  channel 1 FIFO non-empty
- out1_ready  input  1  channel 1 consumer accepts
- out0_count  output  CW  channel 0 occupancy
- out1_count  output  CW  channel 1 occupancy

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state:
  - All pointers and counts go to 0.
  - out0_valid and out1_valid go to 0.
  - All storage goes to 0, so out0_data and out1_data read 0.
  - in_ready is 1 after reset (both FIFOs empty).
- Reset asserted mid-operation discards all buffered words immediately; there is no drain.
- Input handshake:
  - in_ready = !full[in_sel], combinational from in_sel and the registered count.
  - A word is accepted on a clk edge where in_valid && in_ready, and is written to the FIFO selected by in_sel.
  - in_data and in_sel must be held stable while in_valid=1 and in_ready=0.
- Output handshake, per channel N:
  - outN_valid = (outN_count != 0), driven from registered state only.
  - outN_data = storage[rd_ptrN], the oldest entry.
  - Pop on an edge where outN_valid && outN_ready.
- Latency: an accepted word appears on its outN_data/outN_valid one cycle after the accept edge. There is no combinational in-to-out bypass.
- Ordering:
  - Within a channel, strict FIFO order.
  - Across channels, no ordering relation.
- Pointer and count rules:
  - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
  - Count rules:
    - push only: count +1
    - pop only: count -1
    - push and pop on the same channel in the same cycle: count unchanged, both pointers advance
    - neither: count holds
- Boundary conditions:
  - Full channel: in_ready=0 for words selecting it, even if the same channel pops that cycle. There is no same-cycle refill of the freed slot; the slot is usable the next cycle.
  - Full channel 0 with in_sel=1 and channel 1 not full: in_ready=1, word accepted into channel 1.
  - Empty channel with outN_ready=1: no pop, count stays 0, pointer unchanged.
  - Push to channel 0 and pop from channel 1 in the same cycle: independent, both take effect.
  - in_valid=0: in_ready still reflects the selected channel but no write occurs.
- Counts never exceed DEPTH and never underflow.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with both FIFOs holding data -> immediately out0_valid=out1_valid=0, counts=0, data outputs 0, in_ready=1 after release.
- Basic routing: push 0xAAAA0001 with sel=0, then 0xBBBB0002 with sel=1, both readies=1 -> out0 presents 0xAAAA0001 one cycle after its accept, out1 presents 0xBBBB0002 one cycle after its accept, each valid for one cycle.
- Fill and backpressure: out0_ready=0, push 0x1,0x2,0x3 to channel 0 -> first two accepted, out0_count=2, in_ready=0 for the third; the same cycle sel=1 gives in_ready=1 and the word lands in channel 1.
- Full with simultaneous pop: channel 0 full, out0_ready=1 and push with sel=0 -> pop of 0x1 occurs, push refused (in_ready=0); next cycle push accepted, order out: 0x1,0x2,0x3.
- Streaming and wrap: both readies=1, push 0x10..0x17 alternating sel each cycle for 8 words -> each channel emits its 4 words in order with 1-cycle latency, counts never exceed 1, pointers wrap without loss.
- Random stress: random in_valid/in_sel/outN_ready for 10k cycles -> scoreboard per channel shows no loss, duplication or reordering, and counts match the model every cycle.
